testport_sniffer: RTL

TESTPORT_SNIFFER -- requirements
Module: testport_sniffer

---
 rtl/testport_sniffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/testport_sniffer.sv
// Captures CPU writes to a test-port word address and frames them between BEGIN/END markers into a small FIFO.
// Optional feature: define TESTPORT_BYTESWAP_EN to byte-reverse write data before compare/capture.
module testport_sniffer #(
   parameter logic [29:0] TEST_PORT    = 30'h10,
   parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
   parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_wen,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        in_frame,
   output logic        frame_done,
   output logic        overflow,
   output logic [7:0]  word_count
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = 32;

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   state_t          state_q;
   logic            wr_seen_q;
   logic [DW-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic            overflow_q;
   logic [7:0]      word_count_q;

   logic [DW-1:0]   cap_data_c;
   logic            qual_c;
   logic            push_req_c;
   logic            full_c;
   logic            pop_c;
   logic            push_c;
   logic            drop_c;

`ifdef TESTPORT_BYTESWAP_EN
   assign cap_data_c = {mem_wdata[7:0], mem_wdata[15:8], mem_wdata[23:16], mem_wdata[31:24]};
`else
   assign cap_data_c = mem_wdata;
`endif

   // A write held across stall cycles qualifies only on its first cycle.
   assign qual_c     = mem_wen && (mem_addr == TEST_PORT) && !wr_seen_q;
   assign push_req_c = qual_c && (state_q == ARMED);
   assign full_c     = (count_q == CW'(FIFO_DEPTH));
   assign pop_c      = (count_q != '0) && out_ready;
   assign push_c     = push_req_c && (!full_c || pop_c);
   assign drop_c     = push_req_c && full_c && !pop_c;
   assign count_d    = count_q + CW'(push_c) - CW'(pop_c);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_seen_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         word_count_q <= '0;
      end else begin
         wr_seen_q <= mem_wen;
         count_q   <= count_d;
         case (state_q)
            IDLE: begin
               if (qual_c && (cap_data_c == BEGIN_SYMBOL)) begin
                  state_q      <= ARMED;
                  word_count_q <= '0;
               end
            end
            ARMED: begin
               // END moves to DONE even if the FIFO had to drop it.
               if (qual_c && (cap_data_c == END_SYMBOL)) begin
                  state_q <= DONE;
               end
            end
            default: state_q <= state_q;
         endcase
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (word_count_q != 8'hFF) begin
               word_count_q <= word_count_q + 8'd1;
            end
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (drop_c) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset; emptiness is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push_c && !rst) begin
         mem_q[wr_ptr_q] <= cap_data_c;
      end
   end

   assign out_valid  = (count_q != '0);
   assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign in_frame   = (state_q == ARMED);
   assign frame_done = (state_q == DONE);
   assign overflow   = overflow_q;
   assign word_count = word_count_q;

endmodule
